// File: rtl/mux_scan_cl.sv
// NCH:1 registered channel mux with direct-select and one-shot auto-scan modes.
// Latency: one cycle from load to out_valid. Backpressure: out_ready low holds the word and freezes the scan.
// Channel indices >= NCH load zero data.
module mux_scan_cl #(
  parameter int NCH = 8,
  parameter int DW  = 1,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH*DW-1:0]   in_data,
  input  logic                mode,
  input  logic [SELW-1:0]     sel,
  input  logic                start,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DW-1:0]       out_data,
  output logic [SELW-1:0]     out_ch,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  localparam logic [SELW-1:0] LAST = SELW'(NCH - 1);

  state_t          state, state_n;
  logic [SELW-1:0] cnt, cnt_n, ld_ch;
  logic            load, free, done_n;
  logic [DW-1:0]   ld_dat;

  assign free = !out_valid || out_ready;
  assign busy = (state != IDLE);

  always_comb begin
    ld_dat = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ld_ch == SELW'(k)) ld_dat = in_data[k*DW +: DW];
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    ld_ch   = sel;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (!mode) begin
          load = free;
        end else if (start) begin
          state_n = SCAN;
          cnt_n   = '0;
        end
      end
      SCAN: begin
        ld_ch = cnt;
        if (free) begin
          load = 1'b1;
          // Counter parks on the last channel; DRAIN waits for its handshake.
          if (cnt == LAST) state_n = DRAIN;
          else             cnt_n   = cnt + SELW'(1);
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      done  <= done_n;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= ld_dat;
        out_ch    <= ld_ch;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_cl.sv
// Bench for mux_scan_cl: NCH=8 instance against a behavioural model, plus NCH=6 out-of-range select.
module tb_mux_scan_cl;
  localparam int NCH = 8;
  localparam int DW  = 4;
  localparam int SW  = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [NCH*DW-1:0] in_data;
  logic mode, start, out_ready;
  logic [SW-1:0] sel;
  logic out_valid, busy, done;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_ch;

  logic [6*DW-1:0] in_data6;
  logic [2:0] sel6;
  logic out_valid6, busy6, done6;
  logic [DW-1:0] out_data6;
  logic [2:0] out_ch6;

  int n_cmp = 0;
  int n_bad = 0;
  int ndone = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mux_scan_cl #(.NCH(NCH), .DW(DW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .mode(mode), .sel(sel),
    .start(start), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ch(out_ch), .busy(busy), .done(done)
  );

  mux_scan_cl #(.NCH(6), .DW(DW)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data6), .mode(1'b0), .sel(sel6),
    .start(1'b0), .out_ready(1'b1), .out_valid(out_valid6),
    .out_data(out_data6), .out_ch(out_ch6), .busy(busy6), .done(done6)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: a scan is a queue of channels still to emit.
  logic            m_valid;
  logic [DW-1:0]   m_data;
  logic [SW-1:0]   m_ch;
  logic            m_done;
  bit              m_scan;
  int              q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_data = '0; m_ch = '0; m_done = 1'b0; m_scan = 1'b0;
      q.delete();
    end else begin : mdl
      bit ld;
      bit fr;
      int ch;
      fr = !m_valid || out_ready;
      ld = 1'b0;
      ch = 0;
      m_done = 1'b0;
      if (m_scan) begin
        if (q.size() > 0) begin
          if (fr) begin ld = 1'b1; ch = q.pop_front(); end
        end else if (m_valid && out_ready) begin
          m_scan = 1'b0;
          m_done = 1'b1;
        end
      end else if (!mode) begin
        if (fr) begin ld = 1'b1; ch = int'(sel); end
      end else if (start) begin
        m_scan = 1'b1;
        q.delete();
        for (int k = 0; k < NCH; k++) q.push_back(k);
      end
      if (ld) begin
        m_valid = 1'b1;
        m_ch    = SW'(ch);
        m_data  = (ch < NCH) ? in_data[ch*DW +: DW] : '0;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (done) ndone++;
    if (chk_en) begin
      chk("mdl_valid", out_valid, m_valid);
      chk("mdl_data",  out_data,  m_data);
      chk("mdl_ch",    out_ch,    m_ch);
      chk("mdl_busy",  busy,      m_scan);
      chk("mdl_done",  done,      m_done);
    end
  end

  // One scan with channel k = k+3; optional stall, disturbance, or reset at a channel.
  task automatic scan(input int stall_at, input int disturb_at, input int rst_at);
    int d0;
    d0 = ndone;
    for (int k = 0; k < NCH; k++) in_data[k*DW +: DW] = DW'(k + 3);
    out_ready = 1'b1;
    mode = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("scan_busy_rise", busy, 1);
    chk("scan_no_load_start", out_valid, 0);
    for (int i = 0; i < NCH; i++) begin
      step();
      start = 1'b0;
      chk("scan_ch", out_ch, i);
      chk("scan_dat", out_data, i + 3);
      chk("scan_vld", out_valid, 1);
      if (i == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_vld", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dat", out_data, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_done", done, 0);
        #2 rst_n = 1'b1;
        mode = 1'b1;
        start = 1'b0;
        repeat (5) begin
          step();
          chk("post_rst_noload", out_valid, 0);
          chk("post_rst_busy", busy, 0);
        end
        return;
      end
      if (i == stall_at) begin
        out_ready = 1'b0;
        repeat (3) begin
          step();
          chk("stall_dat", out_data, i + 3);
          chk("stall_ch", out_ch, i);
          chk("stall_vld", out_valid, 1);
        end
        out_ready = 1'b1;
      end
      if (i == disturb_at) begin
        start = 1'b1;
        mode = 1'b0;
        sel = SW'($urandom_range(0, 7));
      end
    end
    step();
    chk("scan_done", done, 1);
    chk("scan_busy_fall", busy, 0);
    chk("scan_vld_drained", out_valid, 0);
    step();
    chk("scan_done_clear", done, 0);
    chk("scan_done_count", ndone - d0, 1);
    mode = 1'b1;
  endtask

  initial begin : main
    logic [7:0] pat;
    int exp1[8];
    int s;
    pat  = 8'b1011_0010;
    exp1 = '{0, 1, 0, 0, 1, 1, 0, 1};
    rst_n = 1'b0;
    in_data = '0;
    mode = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    sel = '0;
    sel6 = '0;
    for (int k = 0; k < 6; k++) in_data6[k*DW +: DW] = DW'(k + 9);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vld", out_valid, 0);
    chk("reset_dat", out_data, 0);
    chk("reset_ch", out_ch, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Direct sweep with a one-bit pattern per channel.
    for (int k = 0; k < NCH; k++) in_data[k*DW +: DW] = {3'b000, pat[k]};
    mode = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      sel = SW'(k);
      step();
      chk("direct_dat", out_data, exp1[k]);
      chk("direct_ch", out_ch, k);
      chk("direct_vld", out_valid, 1);
    end

    scan(-1, -1, -1);
    scan(2, -1, -1);
    scan(-1, 3, -1);
    scan(-1, -1, 4);

    // NCH=6 instance: out-of-range select yields zero data, not an error.
    sel6 = 3'd7;
    step();
    chk("n6_sel7_dat", out_data6, 0);
    chk("n6_sel7_ch", out_ch6, 7);
    chk("n6_sel7_vld", out_valid6, 1);
    sel6 = 3'd5;
    step();
    chk("n6_sel5_dat", out_data6, 14);
    chk("n6_sel5_ch", out_ch6, 5);
    for (int i = 0; i < 20; i++) begin
      s = $urandom_range(0, 7);
      sel6 = 3'(s);
      step();
      chk("n6_rand_dat", out_data6, (s < 6) ? s + 9 : 0);
      chk("n6_rand_ch", out_ch6, s);
    end

    for (int c = 0; c < 3000; c++) begin
      in_data = $urandom;
      mode = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 5) == 0);
      sel = SW'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
